pulse_sync_sched: RTL and testbench

//   Source-domain scheduler sharing one toggle-based pulse synchronizer between N requesters.
//   - Collects single-cycle event pulses per requester and grants them round-robin.
//   - Emits one pulse per slot, with requester ID, enforcing a programmable minimum spacing
//     so the destination domain samples every toggle.
//   - Sits between event sources and the synchronizer's s_pluse input; sync_id travels alongside.

---
 rtl/pulse_sched_pkg.sv | 19 +
 rtl/pulse_rr_pick.sv | 34 +++
 rtl/pulse_sync_sched.sv | 193 +++++++++++++++++++
 tb/tb_pulse_sync_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse synchronizer scheduler.
//   state_t  : scheduler FSM states (idle, issue one pulse, enforce spacing gap)
//   ST_W     : width of the state encoding
//   DEF_*    : default parameter values for the requester count, gap width and
//              pending-counter width
package pulse_sched_pkg;

    localparam int ST_W   = 2;
    localparam int DEF_N  = 4;
    localparam int DEF_GW = 4;
    localparam int DEF_CW = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_rr_pick.sv
// Combinational round-robin picker.
//   pending   in  N    requesters with at least one unserved event
//   pointer   in  IDW  index with highest priority this round
//   grant     out IDW  first pending index at/after pointer, wrapping mod N
//   any_valid out 1    at least one requester is pending
module pulse_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   pending,
    input  logic [IDW-1:0] pointer,
    output logic [IDW-1:0] grant,
    output logic           any_valid
);

    // Walk offsets from the far end down to 0 so the closest pending index
    // to the pointer is the last one written and therefore wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(pointer) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (pending[j]) begin
                grant     = IDW'(j);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_sync_sched.sv
// Source-domain scheduler that shares one toggle pulse synchronizer between
// N requesters. Events are stored per requester, granted round-robin, and
// issued as single-cycle pulses separated by at least gap_cfg+2 cycles so the
// destination domain sees every toggle.
//
// Ports:
//   src_clk    in   1    source-domain clock
//   src_rst    in   1    synchronous reset, active-high
//   enable     in   1    allow new grants from idle (pending keeps collecting)
//   req_pulse  in   N    one-cycle event per requester
//   gap_cfg    in   GW   extra idle cycles after each issued pulse
//   ovf_clr    in   1    clear all sticky overflow flags
//   sync_pulse out  1    registered pulse to the synchronizer input
//   sync_id    out  IDW  registered requester id, valid with sync_pulse
//   busy       out  1    scheduler is issuing or spacing
//   pending    out  N    requester has at least one unserved event
//   ovf_sticky out  N    an event from the requester was dropped
//
// Build option: define PULSE_SCHED_CNT_EN to store up to 2^CW-1 events per
// requester in a saturating counter; otherwise each requester holds a single
// pending bit and repeated events coalesce.
module pulse_sync_sched
    import pulse_sched_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = $clog2(N),
    parameter int GW  = DEF_GW,
    parameter int CW  = DEF_CW
) (
    input  logic           src_clk,
    input  logic           src_rst,
    input  logic           enable,
    input  logic [N-1:0]   req_pulse,
    input  logic [GW-1:0]  gap_cfg,
    input  logic           ovf_clr,
    output logic           sync_pulse,
    output logic [IDW-1:0] sync_id,
    output logic           busy,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   ovf_sticky
);

    if (N < 2 || N > 16 || CW < 1 || IDW < $clog2(N)) begin : g_param_err
        $error("pulse_sync_sched: unsupported parameter combination");
    end

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           sync_pulse_q, sync_pulse_d;
    logic [IDW-1:0] sync_id_q, sync_id_d;
    logic [N-1:0]   ovf_q, ovf_d;
    logic [N-1:0]   cons;
    logic [N-1:0]   set_ovf;
    logic [N-1:0]   pend_vec;
    logic [IDW-1:0] pick_idx;
    logic           pick_vld;

    pulse_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .pending   (pend_vec),
        .pointer   (ptr_q),
        .grant     (pick_idx),
        .any_valid (pick_vld)
    );

`ifdef PULSE_SCHED_CNT_EN
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];

    // A simultaneous arrival and consume leaves the count unchanged; a full
    // counter only overflows when nothing is consumed in the same cycle.
    always_comb begin
        set_ovf  = '0;
        pend_vec = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d[i]    = cnt_q[i];
            pend_vec[i] = (cnt_q[i] != '0);
            if (req_pulse[i] && !cons[i]) begin
                if (&cnt_q[i]) begin
                    set_ovf[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else if (cons[i] && !req_pulse[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge src_clk) begin
        for (int i = 0; i < N; i++) begin
            if (src_rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    logic [N-1:0] pend_q, pend_d;

    // Arrival wins over consume, so an event landing in its own issue cycle
    // stays pending; a set bit that is not consumed drops the new event.
    always_comb begin
        pend_d   = (pend_q & ~cons) | req_pulse;
        set_ovf  = pend_q & req_pulse & ~cons;
        pend_vec = pend_q;
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`endif

    // A new overflow outranks a clear in the same cycle.
    always_comb begin
        ovf_d = set_ovf | (ovf_q & ~{N{ovf_clr}});
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        gap_d        = gap_q;
        sync_pulse_d = 1'b0;
        sync_id_d    = '0;
        cons         = '0;
        case (state_q)
            ST_IDLE: begin
                // The pulse register is loaded on the transition so it is
                // high exactly while the FSM sits in ISSUE.
                if (enable && pick_vld) begin
                    state_d      = ST_ISSUE;
                    grant_d      = pick_idx;
                    sync_pulse_d = 1'b1;
                    sync_id_d    = pick_idx;
                end
            end
            ST_ISSUE: begin
                cons[grant_q] = 1'b1;
                ptr_d         = (grant_q == IDW'(N - 1)) ? '0 : grant_q + IDW'(1);
                gap_d         = gap_cfg;
                state_d       = (gap_cfg != '0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                // Loaded with gap_cfg, so the FSM spends exactly gap_cfg
                // cycles here before returning to IDLE.
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (src_rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            gap_q        <= '0;
            sync_pulse_q <= 1'b0;
            sync_id_q    <= '0;
            ovf_q        <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            gap_q        <= gap_d;
            sync_pulse_q <= sync_pulse_d;
            sync_id_q    <= sync_id_d;
            ovf_q        <= ovf_d;
        end
    end

    assign sync_pulse = sync_pulse_q;
    assign sync_id    = sync_id_q;
    assign busy       = (state_q != ST_IDLE);
    assign pending    = pend_vec;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_pulse_sync_sched.sv
// Self-checking bench for pulse_sync_sched (N=4). A timestamp-based reference
// model predicts every output each cycle; directed tables and sequences check
// the documented latency, round-robin order, spacing, overflow and reset cases.
module tb_pulse_sync_sched;

    localparam int N = 4;
`ifdef PULSE_SCHED_CNT_EN
    localparam int CAP = 7;
`else
    localparam int CAP = 1;
`endif

    logic       src_clk = 1'b0;
    logic       src_rst;
    logic       enable;
    logic [3:0] req_pulse;
    logic [3:0] gap_cfg;
    logic       ovf_clr;
    logic       sync_pulse;
    logic [1:0] sync_id;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] ovf_sticky;

    always #5 src_clk = ~src_clk;

    pulse_sync_sched dut (
        .src_clk    (src_clk),
        .src_rst    (src_rst),
        .enable     (enable),
        .req_pulse  (req_pulse),
        .gap_cfg    (gap_cfg),
        .ovf_clr    (ovf_clr),
        .sync_pulse (sync_pulse),
        .sync_id    (sync_id),
        .busy       (busy),
        .pending    (pending),
        .ovf_sticky (ovf_sticky)
    );

    int errors = 0;
    int checks = 0;
    int tcyc   = 0;
    int t0     = 0;
    bit model_valid = 1'b0;

    logic       obs_pulse;
    logic [1:0] obs_id;
    logic       obs_busy;
    logic [3:0] obs_pend;
    logic [3:0] obs_ovf;
    int p_cyc[$];
    int p_id[$];

    // Reference model: event counts per requester plus the time of the next
    // scheduled pulse and the last cycle the scheduler stays busy.
    int m_cnt[N];
    bit m_ovf[N];
    int m_ptr;
    int m_issue_at;
    int m_issue_id;
    int m_busy_until;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
        end
        m_ptr        = 0;
        m_issue_at   = -1;
        m_issue_id   = 0;
        m_busy_until = -1;
    endtask

    task automatic step(input logic [3:0] r, input logic e, input logic [3:0] g,
                        input logic c, input logic rs);
        logic        ep;
        logic [1:0]  eid;
        logic        eb;
        logic [3:0]  epd;
        logic [3:0]  eov;
        logic [13:0] exp_v;
        logic [13:0] act_v;
        bit          idle;
        bit          found;
        bit [3:0]    cons;
        req_pulse = r;
        enable    = e;
        gap_cfg   = g;
        ovf_clr   = c;
        src_rst   = rs;
        @(negedge src_clk);
        ep  = (m_issue_at == tcyc);
        eid = ep ? 2'(m_issue_id) : 2'd0;
        eb  = ep || (tcyc <= m_busy_until);
        for (int i = 0; i < N; i++) begin
            epd[i] = (m_cnt[i] > 0);
            eov[i] = m_ovf[i];
        end
        obs_pulse = sync_pulse;
        obs_id    = sync_id;
        obs_busy  = busy;
        obs_pend  = pending;
        obs_ovf   = ovf_sticky;
        if (model_valid) begin
            exp_v = {ep, eid, eb, epd, eov};
            act_v = {obs_pulse, obs_id, obs_busy, obs_pend, obs_ovf};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL model cycle %0d: got pulse/id/busy/pend/ovf=%b expected %b",
                         tcyc, act_v, exp_v);
            end
        end
        if (obs_pulse === 1'b1) begin
            p_cyc.push_back(tcyc - t0);
            p_id.push_back(int'(obs_id));
        end
        if (rs) begin
            model_reset();
            model_valid = 1'b1;
        end else begin
            idle = (m_issue_at < 0) && (tcyc > m_busy_until);
            cons = '0;
            if (ep) begin
                cons[m_issue_id] = 1'b1;
                m_ptr        = (m_issue_id + 1) % N;
                m_busy_until = tcyc + int'(g);
                m_issue_at   = -1;
            end
            if (idle && e) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && m_cnt[(m_ptr + k) % N] > 0) begin
                        found      = 1'b1;
                        m_issue_at = tcyc + 1;
                        m_issue_id = (m_ptr + k) % N;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                bit so;
                so = 1'b0;
                if (r[i] && !cons[i]) begin
                    if (m_cnt[i] == CAP) so = 1'b1;
                    else m_cnt[i]++;
                end else if (cons[i] && !r[i]) begin
                    m_cnt[i]--;
                end
                m_ovf[i] = so || (m_ovf[i] && !c);
            end
        end
        @(posedge src_clk);
        #1;
        tcyc++;
    endtask

    task automatic do_reset();
        step(4'd0, 1'b0, 4'd2, 1'b0, 1'b1);
        t0 = tcyc;
        p_cyc.delete();
        p_id.delete();
    endtask

    typedef struct {
        logic       rst_first;
        logic [3:0] req;
        logic       exp_pulse;
        logic [1:0] exp_id;
        logic       exp_busy;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t tv[25];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_id1;
        // single event on requester 2
        tv[0]  = '{1'b1, 4'b0100, 1'b0, 2'd0, 1'b0, 4'b0000};
        tv[1]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0100};
        tv[2]  = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b0100};
        tv[3]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000};
        tv[4]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000};
        tv[5]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000};
        tv[6]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000};
        // all four at once: ids 0..3 at cycles 2,6,10,14
        tv[7]  = '{1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000};
        tv[8]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1111};
        tv[9]  = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b1111};
        tv[10] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1110};
        tv[11] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1110};
        tv[12] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1110};
        tv[13] = '{1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b1110};
        tv[14] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1100};
        tv[15] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1100};
        tv[16] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1100};
        tv[17] = '{1'b0, 4'b0000, 1'b1, 2'd2, 1'b1, 4'b1100};
        tv[18] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1000};
        tv[19] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1000};
        tv[20] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1000};
        tv[21] = '{1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b1000};
        tv[22] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000};
        tv[23] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000};
        tv[24] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000};

        req_pulse = '0;
        enable    = 1'b0;
        gap_cfg   = 4'd2;
        ovf_clr   = 1'b0;
        src_rst   = 1'b1;

        do_reset();
        step(4'd0, 1'b0, 4'd2, 1'b0, 1'b0);
        check("reset_state", int'({obs_pulse, obs_id, obs_busy, obs_pend, obs_ovf}), 0);

        for (int i = 0; i < 25; i++) begin
            if (tv[i].rst_first) do_reset();
            step(tv[i].req, 1'b1, 4'd2, 1'b0, 1'b0);
            check($sformatf("vec%0d_pulse", i), int'(obs_pulse), int'(tv[i].exp_pulse));
            check($sformatf("vec%0d_id", i), int'(obs_id), int'(tv[i].exp_id));
            check($sformatf("vec%0d_busy", i), int'(obs_busy), int'(tv[i].exp_busy));
            check($sformatf("vec%0d_pend", i), int'(obs_pend), int'(tv[i].exp_pend));
        end

        // spacing with gap_cfg = 0 and 5
        do_reset();
        step(4'b0011, 1'b1, 4'd0, 1'b0, 1'b0);
        repeat (8) step(4'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        check("gap0_count", p_cyc.size(), 2);
        if (p_cyc.size() == 2) begin
            check("gap0_first", p_cyc[0], 2);
            check("gap0_second", p_cyc[1], 4);
        end
        do_reset();
        step(4'b0011, 1'b1, 4'd5, 1'b0, 1'b0);
        repeat (12) step(4'd0, 1'b1, 4'd5, 1'b0, 1'b0);
        check("gap5_count", p_cyc.size(), 2);
        if (p_cyc.size() == 2) begin
            check("gap5_first", p_cyc[0], 2);
            check("gap5_second", p_cyc[1], 9);
        end

        // overflow on requester 1 while disabled
        do_reset();
        repeat (CAP) step(4'b0010, 1'b0, 4'd2, 1'b0, 1'b0);
        step(4'd0, 1'b0, 4'd2, 1'b0, 1'b0);
        check("ovf_before_full", int'(obs_ovf), 0);
        check("pend_when_full", int'(obs_pend), 2);
        step(4'b0010, 1'b0, 4'd2, 1'b0, 1'b0);
        step(4'd0, 1'b0, 4'd2, 1'b0, 1'b0);
        check("ovf_after_drop", int'(obs_ovf), 2);
        check("no_grant_disabled", int'(obs_busy), 0);
        p_cyc.delete();
        p_id.delete();
        repeat (CAP * 4 + 8) step(4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
        cnt_id1 = 0;
        foreach (p_id[k]) if (p_id[k] == 1) cnt_id1++;
        check("ovf_pulse_count", p_id.size(), CAP);
        check("ovf_pulse_id1", cnt_id1, CAP);
        check("ovf_held", int'(obs_ovf), 2);
        step(4'd0, 1'b1, 4'd2, 1'b1, 1'b0);
        step(4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
        check("ovf_cleared", int'(obs_ovf), 0);

        // new request on requester 0 during its own issue cycle
        do_reset();
        step(4'b0001, 1'b1, 4'd2, 1'b0, 1'b0);
        step(4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 4'd2, 1'b0, 1'b0);
        check("simul_issue", int'(obs_pulse), 1);
        repeat (8) step(4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
        check("simul_count", p_cyc.size(), 2);
        if (p_cyc.size() == 2) begin
            check("simul_second", p_cyc[1], 6);
            check("simul_id", p_id[1], 0);
        end
        check("simul_ovf", int'(obs_ovf), 0);

        // reset in the middle of a gap
        do_reset();
        step(4'b0100, 1'b1, 4'd2, 1'b0, 1'b0);
        step(4'b0100, 1'b1, 4'd2, 1'b0, 1'b0);
        step(4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
        check("rst_pre_pulse", int'(obs_pulse), 1);
        step(4'd0, 1'b1, 4'd2, 1'b0, 1'b1);
        step(4'b1010, 1'b1, 4'd2, 1'b0, 1'b0);
        check("rst_outputs", int'({obs_pulse, obs_id, obs_busy, obs_pend, obs_ovf}), 0);
        step(4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
        step(4'd0, 1'b1, 4'd2, 1'b0, 1'b0);
        check("rst_fresh_pulse", int'(obs_pulse), 1);
        check("rst_fresh_id", int'(obs_id), 1);

        // random traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] r;
            for (int b = 0; b < 4; b++) r[b] = ($urandom % 5 == 0);
            step(r, ($urandom % 4 != 0), 4'($urandom % 5), ($urandom % 16 == 0),
                 ($urandom % 300 == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
